// File: rtl/add_pkg.sv
// Shared constants and stage-1 payload layout for the split-carry 64-bit adder.
package add_pkg;

    localparam int DATA_W = 64;
    localparam int HALF_W = DATA_W / 2;

    // Everything stage 2 needs to finish the upper half and compute overflow.
    typedef struct packed {
        logic [HALF_W-1:0] lo_sum;
        logic              c_mid;
        logic [HALF_W-1:0] a_hi;
        logic [HALF_W-1:0] bp_hi;
        logic              a_msb;
        logic              bp_msb;
    } s1_payload_t;

endpackage

// File: rtl/add_pipe_64b_adder_slice.sv
// Combinational W-bit ripple-carry adder; one slice per pipeline stage keeps
// each stage's carry path to half the word width.
module adder_slice #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W:0] c;

    assign c[0] = cin;

    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
        assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end

    assign cout = c[W];

endmodule

// File: rtl/add_pipe_64b.sv
// Two-stage pipelined adder/subtractor: low half + carry registered in stage 1,
// upper half completed in stage 2. Valid/ready on both sides, two-entry capacity.
module add_pipe_64b
    import add_pkg::*;
#(
    parameter int N = DATA_W
) (
    input  logic         clk,
    input  logic         rst_a,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int H = N / 2;

    logic [N-1:0] bp;
    logic         c0;
    logic [H-1:0] lo_sum;
    logic         c_mid;
    logic [H-1:0] hi_sum;
    logic         hi_cout;
    logic         ovf_next;

    s1_payload_t  s1_next;
    s1_payload_t  s1_reg;
    logic         s1_valid_reg;

    logic [N-1:0] sum_reg;
    logic         cout_reg;
    logic         ovf_reg;
    logic         s2_valid_reg;

    logic         s1_adv;
    logic         s2_adv;

    // Subtract is A + ~B + 1; cin is ignored in that mode.
    assign bp = sub ? ~b : b;
    assign c0 = sub | cin;

    adder_slice #(.W(H)) u_lo (
        .a    (a[H-1:0]),
        .b    (bp[H-1:0]),
        .cin  (c0),
        .s    (lo_sum),
        .cout (c_mid)
    );

    always_comb begin
        s1_next        = '0;
        s1_next.lo_sum = lo_sum;
        s1_next.c_mid  = c_mid;
        s1_next.a_hi   = a[N-1:H];
        s1_next.bp_hi  = bp[N-1:H];
        s1_next.a_msb  = a[N-1];
        s1_next.bp_msb = bp[N-1];
    end

    adder_slice #(.W(H)) u_hi (
        .a    (s1_reg.a_hi),
        .b    (s1_reg.bp_hi),
        .cin  (s1_reg.c_mid),
        .s    (hi_sum),
        .cout (hi_cout)
    );

    assign ovf_next = (s1_reg.a_msb == s1_reg.bp_msb) && (hi_sum[H-1] != s1_reg.a_msb);

    // Stage 2 frees up whenever it drains, so out_ready reaches in_ready combinationally.
    assign s2_adv   = s1_valid_reg && (!s2_valid_reg || out_ready);
    assign in_ready = !s1_valid_reg || !s2_valid_reg || out_ready;
    assign s1_adv   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_a) begin
            s1_reg       <= '0;
            s1_valid_reg <= 1'b0;
            sum_reg      <= '0;
            cout_reg     <= 1'b0;
            ovf_reg      <= 1'b0;
            s2_valid_reg <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_reg <= s1_next;
            end
            s1_valid_reg <= s1_adv || (s1_valid_reg && !s2_adv);

            if (s2_adv) begin
                sum_reg  <= {hi_sum, s1_reg.lo_sum};
                cout_reg <= hi_cout;
                ovf_reg  <= ovf_next;
            end
            s2_valid_reg <= s2_adv || (s2_valid_reg && !out_ready);
        end
    end

    assign out_valid = s2_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_add_pipe_64b.sv
// Directed and streaming checks for the two-stage 64-bit adder/subtractor.
module tb_add_pipe_64b;

    logic        clk = 1'b0;
    logic        rst_a = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;

    int checks = 0;
    int failures = 0;

    add_pipe_64b dut (
        .clk       (clk),
        .rst_a     (rst_a),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one operand through an empty pipeline and returns what was observed.
    task automatic do_op(input logic [63:0] ta, input logic [63:0] tb_v, input logic tcin,
                         input logic tsub, output logic acc, output logic v1, output logic v2,
                         output logic [63:0] osum, output logic ocout, output logic oovf);
        a = ta; b = tb_v; cin = tcin; sub = tsub;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        acc = in_ready;
        tick();
        in_valid = 1'b0;
        #1;
        v1 = out_valid;
        tick();
        #1;
        v2 = out_valid; osum = sum; ocout = cout; oovf = ovf;
        tick();
    endtask

    task automatic test_reset();
        rst_a = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) tick();
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        checks++; if (sum !== 64'h0) begin failures++; $display("FAIL reset_sum: got %h required 0", sum); end
        checks++; if ({cout, ovf} !== 2'b00) begin failures++; $display("FAIL reset_flags: got cout=%b ovf=%b required 0 0", cout, ovf); end
        rst_a = 1'b1;
        tick();
    endtask

    task automatic test_add_carry();
        logic acc, v1, v2, oc, oo;
        logic [63:0] os;
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, acc, v1, v2, os, oc, oo);
        checks++; if (acc !== 1'b1) begin failures++; $display("FAIL carry_accept: got in_ready=%b required 1", acc); end
        checks++; if (v1 !== 1'b0) begin failures++; $display("FAIL carry_latency_early: got out_valid=%b required 0", v1); end
        checks++; if (v2 !== 1'b1) begin failures++; $display("FAIL carry_latency: got out_valid=%b required 1", v2); end
        checks++; if ({os, oc, oo} !== {64'h0, 1'b1, 1'b0}) begin failures++; $display("FAIL carry_through: got sum=%h cout=%b ovf=%b required 0 1 0", os, oc, oo); end
        do_op(64'd10, 64'd20, 1'b1, 1'b0, acc, v1, v2, os, oc, oo);
        checks++; if ({v2, os, oc, oo} !== {1'b1, 64'd31, 1'b0, 1'b0}) begin failures++; $display("FAIL add_cin: got v=%b sum=%h cout=%b ovf=%b required 1 1f 0 0", v2, os, oc, oo); end
    endtask

    task automatic test_mid_split();
        logic acc, v1, v2, oc, oo;
        logic [63:0] os;
        do_op(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, acc, v1, v2, os, oc, oo);
        checks++; if ({v2, os, oc, oo} !== {1'b1, 64'h0000_0001_0000_0000, 1'b0, 1'b0}) begin failures++; $display("FAIL mid_split: got v=%b sum=%h cout=%b ovf=%b required 1 0000000100000000 0 0", v2, os, oc, oo); end
    endtask

    task automatic test_subtract();
        logic acc, v1, v2, oc, oo;
        logic [63:0] os;
        do_op(64'd5, 64'd7, 1'b0, 1'b1, acc, v1, v2, os, oc, oo);
        checks++; if ({v2, os, oc, oo} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0}) begin failures++; $display("FAIL sub_borrow: got v=%b sum=%h cout=%b ovf=%b required 1 fffffffffffffffe 0 0", v2, os, oc, oo); end
        do_op(64'd100, 64'd40, 1'b1, 1'b1, acc, v1, v2, os, oc, oo);
        checks++; if ({v2, os, oc, oo} !== {1'b1, 64'd60, 1'b1, 1'b0}) begin failures++; $display("FAIL sub_ignore_cin: got v=%b sum=%h cout=%b ovf=%b required 1 3c 1 0", v2, os, oc, oo); end
    endtask

    task automatic test_overflow();
        logic acc, v1, v2, oc, oo;
        logic [63:0] os;
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, acc, v1, v2, os, oc, oo);
        checks++; if ({v2, os, oc, oo} !== {1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1}) begin failures++; $display("FAIL add_ovf: got v=%b sum=%h cout=%b ovf=%b required 1 8000000000000000 0 1", v2, os, oc, oo); end
        do_op(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, acc, v1, v2, os, oc, oo);
        checks++; if ({v2, os, oc, oo} !== {1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1}) begin failures++; $display("FAIL sub_ovf: got v=%b sum=%h cout=%b ovf=%b required 1 7fffffffffffffff 1 1", v2, os, oc, oo); end
    endtask

    task automatic test_backpressure();
        logic [63:0] ea [4];
        logic [63:0] eb [4];
        logic [63:0] es [4];
        logic        ec [4];
        int idx = 0;
        int got = 0;
        ea[0] = 64'h1;                   eb[0] = 64'h2;                   es[0] = 64'h3;                   ec[0] = 1'b0;
        ea[1] = 64'h0000_0000_FFFF_FFFF; eb[1] = 64'h2;                   es[1] = 64'h0000_0001_0000_0001; ec[1] = 1'b0;
        ea[2] = 64'h10;                  eb[2] = 64'h20;                  es[2] = 64'h30;                  ec[2] = 1'b0;
        ea[3] = 64'hFFFF_FFFF_FFFF_FFFF; eb[3] = 64'hFFFF_FFFF_FFFF_FFFF; es[3] = 64'hFFFF_FFFF_FFFF_FFFE; ec[3] = 1'b1;
        out_ready = 1'b0; cin = 1'b0; sub = 1'b0;
        for (int n = 0; n < 2; n++) begin
            a = ea[idx]; b = eb[idx]; in_valid = 1'b1;
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_fill%0d: got in_ready=%b required 1", n, in_ready); end
            if (in_ready) idx++;
            tick();
        end
        a = ea[idx]; b = eb[idx];
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got %b required 0", in_ready); end
        checks++; if ({out_valid, sum} !== {1'b1, es[0]}) begin failures++; $display("FAIL bp_head: got v=%b sum=%h required 1 %h", out_valid, sum, es[0]); end
        tick();
        #1;
        checks++; if ({out_valid, sum} !== {1'b1, es[0]}) begin failures++; $display("FAIL bp_hold: got v=%b sum=%h required 1 %h", out_valid, sum, es[0]); end
        out_ready = 1'b1;
        for (int n = 0; n < 20 && got < 4; n++) begin
            if (idx < 4) begin a = ea[idx]; b = eb[idx]; in_valid = 1'b1; end
            else in_valid = 1'b0;
            #1;
            if (out_valid) begin
                checks++;
                if ({sum, cout} !== {es[got], ec[got]}) begin failures++; $display("FAIL bp_result%0d: got sum=%h cout=%b required %h %b", got, sum, cout, es[got], ec[got]); end
                got++;
            end
            if (in_valid && in_ready) idx++;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (got !== 4 || idx !== 4) begin failures++; $display("FAIL bp_count: got results=%0d accepts=%0d required 4 4", got, idx); end
    endtask

    task automatic test_reset_midflight();
        logic seen = 1'b0;
        out_ready = 1'b0; cin = 1'b0; sub = 1'b0;
        a = 64'h11; b = 64'h22; in_valid = 1'b1;
        tick();
        a = 64'h33; b = 64'h44;
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if ({out_valid, in_ready} !== 2'b10) begin failures++; $display("FAIL rst_mid_full: got v=%b in_ready=%b required 1 0", out_valid, in_ready); end
        rst_a = 1'b0;
        tick();
        #1;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL rst_mid_hs: got v=%b in_ready=%b required 0 1", out_valid, in_ready); end
        checks++; if ({sum, cout, ovf} !== 66'h0) begin failures++; $display("FAIL rst_mid_data: got sum=%h cout=%b ovf=%b required 0 0 0", sum, cout, ovf); end
        rst_a = 1'b1; out_ready = 1'b1;
        repeat (4) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_mid_discard: got stale out_valid=%b required 0", seen); end
    endtask

    task automatic test_streaming();
        logic [63:0] sa [16];
        logic [63:0] sb [16];
        logic        sc [16];
        logic        ss [16];
        logic [63:0] es [16];
        logic        ec [16];
        logic        eo [16];
        logic [64:0] full;
        int idx = 0;
        int got = 0;
        int first_acc = -1;
        for (int i = 0; i < 16; i++) begin
            sa[i] = {$urandom(), $urandom()};
            sb[i] = {$urandom(), $urandom()};
            sc[i] = 1'($urandom_range(0, 1));
            ss[i] = 1'($urandom_range(0, 1));
            if (ss[i]) begin
                full  = {1'b0, sa[i]} - {1'b0, sb[i]};
                ec[i] = (sa[i] >= sb[i]);
                eo[i] = (sa[i][63] != sb[i][63]) && (full[63] != sa[i][63]);
            end else begin
                full  = {1'b0, sa[i]} + {1'b0, sb[i]} + 65'(sc[i]);
                ec[i] = full[64];
                eo[i] = (sa[i][63] == sb[i][63]) && (full[63] != sa[i][63]);
            end
            es[i] = full[63:0];
        end
        out_ready = 1'b1;
        for (int n = 0; n < 40 && got < 16; n++) begin
            if (idx < 16) begin
                a = sa[idx]; b = sb[idx]; cin = sc[idx]; sub = ss[idx]; in_valid = 1'b1;
            end else in_valid = 1'b0;
            #1;
            if (out_valid) begin
                checks++;
                if ({sum, cout, ovf} !== {es[got], ec[got], eo[got]} || n !== first_acc + 2 + got) begin
                    failures++;
                    $display("FAIL stream%0d: got sum=%h cout=%b ovf=%b cycle=%0d required %h %b %b cycle=%0d",
                             got, sum, cout, ovf, n, es[got], ec[got], eo[got], first_acc + 2 + got);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                if (idx == 0) first_acc = n;
                idx++;
            end
            tick();
        end
        in_valid = 1'b0;
        checks++; if (got !== 16) begin failures++; $display("FAIL stream_count: got %0d required 16", got); end
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_mid_split();
        test_subtract();
        test_overflow();
        test_backpressure();
        test_reset_midflight();
        test_streaming();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/add_pipe_64b.md
# add_pipe_64b

Two-stage pipelined 64-bit adder/subtractor that produces the operand word for the 64-bit universal shift register. It accepts operand pairs over a valid/ready handshake and splits the carry chain into two registered halves, so each stage has only a 32-bit ripple path. The `sum`/`out_valid` pair drives the shifter's `ip`/`load` inputs directly. Sustained throughput is one result per cycle; latency is two cycles.

## Interface
- `N`, 64: operand/result width; must be even.
- `H`, N/2: low-half width; fixed derived constant, not overridden.
- `clk`  in  1  rising-edge clock; sole clock.
- `rst_a`  in  1  synchronous, active-low reset, sampled on rising `clk`.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  stage 1 can accept this cycle.
- `a`  in  N  operand A.
- `b`  in  N  operand B.
- `cin`  in  1  carry-in; used only when `sub`=0.
- `sub`  in  1  1: A−B (B inverted, carry-in forced to 1); 0: A+B+cin.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  downstream (shifter load) accepts.
- `sum`  out  N  result, modulo 2^N.
- `cout`  out  1  carry out of bit N−1; for subtract, 1 = no borrow.
- `ovf`  out  1  two's-complement signed overflow.

## Operation
- A transfer occurs on any rising edge where valid && ready, on either port.
- Stage 1, on accept:
  - bp = sub ? ~b : b; c0 = sub ? 1 : cin.
  - Registers lo_sum = a[H-1:0]+bp[H-1:0]+c0 (H bits) and carry c_mid.
  - Registers a[N-1:H], bp[N-1:H], and the sign bits a[N-1] and bp[N-1].
  - Sets s1_valid.
- Stage 2, on advance:
  - hi = a_hi + bp_hi + c_mid.
  - sum = {hi, lo_sum}; cout = carry out of hi.
  - ovf = (a[N-1] == bp[N-1]) && (sum[N-1] != a[N-1]).
  - Sets s2_valid.
- Advance rules:
  - s2_adv = s1_valid && (!s2_valid || out_ready).
  - s1_adv (accept) = in_valid && in_ready.
  - in_ready = !s1_valid || !s2_valid || out_ready. The combinational out_ready→in_ready path is permitted.
- Stall: while out_valid && !out_ready, `sum`, `cout` and `ovf` hold. Stage 1 holds if it is also occupied. No transaction is lost, duplicated or reordered.
- Simultaneous events:
  - Output drain, s1→s2 move and a new accept can all occur in the same cycle.
  - Stage-1 registers are overwritten only when stage 1 is empty or advancing.
- When `in_valid`=0, operand values are don't-care. The upstream side holds a, b, cin and sub stable while in_valid && !in_ready.

## Timing
- Reset (rst_a=0 at an edge) clears s1_valid, s2_valid, sum, cout, ovf and all pipeline data to 0.
- Out of reset: out_valid=0, in_ready=1.
- Reset has priority over all handshakes. Reset mid-operation discards in-flight data; out_valid is 0 in the cycle after the reset edge.
- Latency: an operand accepted at edge k appears on out_valid/sum after edge k+1 (two registered stages), when downstream is not stalled.
- Throughput: 1 transfer per cycle with out_ready held at 1.
- Capacity: 2 transactions buffered. in_ready falls only when both stages are full and out_ready=0.
- Critical path: one H-bit ripple plus mux. No path spans the full N bits.

## Structure
- Shared package `add_pkg`:
  - Constants DATA_W=64 and HALF_W=DATA_W/2.
  - Typedef for the stage-1 payload struct {lo_sum, c_mid, a_hi, bp_hi, a_msb, bp_msb}.
- Sub-module `adder_slice #(W)`: combinational W-bit ripple adder with cin/cout. Instantiated twice, at W=H: once in stage 1 and once in stage 2.
- Top level holds the handshake/valid logic and the pipeline registers only.

## Test plan
- Add carry-through: a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0, sub=0 -> sum=0, cout=1, ovf=0; out_valid asserted exactly 2 cycles after accept.
- Mid-split carry: a=0x0000_0000_FFFF_FFFF, b=1 -> sum=0x0000_0001_0000_0000, cout=0.
- Subtract and overflow:
  - a=5, b=7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
  - a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=0x8000_0000_0000_0000, ovf=1.
- Backpressure: 4 back-to-back operands with out_ready=0 for 3 cycles -> in_ready=0 after 2 accepts, sum held stable, all 4 results delivered in order once out_ready=1.
- Reset mid-flight: both stages full, rst_a=0 for one edge -> next cycle out_valid=0, sum=0, in_ready=1; the in-flight results never appear.
- Streaming: in_valid=out_ready=1 for 16 cycles with random operands -> 16 results, one per cycle, first 2 cycles after the first accept, each matching the reference model modulo 2^64.
